// File: rtl/spe_packet_sequencer.sv
// spe_packet_sequencer: buffers partial sums and emits psum, previous-potential and
// timestep-done packets toward the spe for each timestep.
module spe_packet_sequencer #(
    parameter int ADDR_WIDTH   = 4,
    parameter int OPCODE_WIDTH = 4,
    parameter int DATA_WIDTH   = 25,
    parameter int PKT_WIDTH    = 33,
    parameter int NUM_PSUMS    = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int NUM_NEURONS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ts_start,
    input  logic [ADDR_WIDTH-1:0] ts_addr,
    output logic                  busy,
    input  logic                  psum_valid,
    output logic                  psum_ready,
    input  logic [DATA_WIDTH-1:0] psum_data,
    input  logic                  pot_wr_en,
    input  logic [ADDR_WIDTH-1:0] pot_wr_addr,
    input  logic [DATA_WIDTH-1:0] pot_wr_data,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [PKT_WIDTH-1:0]  pkt_data,
    output logic                  ts_done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [OPCODE_WIDTH-1:0] OP_PSUM = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_DONE = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_POT  = OPCODE_WIDTH'(2);

    typedef enum logic [2:0] {IDLE, PSUM, POT, FLAG, DRAIN} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] pot_table [NUM_NEURONS];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic [7:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  loadable, load, fifo_rd, fifo_wr, pot_wr_ok, pot_hit;
    logic [PKT_WIDTH-1:0]  load_data;
    logic [DATA_WIDTH-1:0] pot_rd;

    assign psum_ready = count != FULL;
    assign fifo_wr    = psum_valid && psum_ready;
    assign loadable   = !pkt_valid || pkt_ready;
    assign busy       = state != IDLE;
    assign ts_done    = state == DRAIN && pkt_valid && pkt_ready;
    assign pot_wr_ok  = pot_wr_en && int'(pot_wr_addr) < NUM_NEURONS;
    // a write landing in the same cycle as the potential load wins over the stale entry
    assign pot_hit    = pot_wr_ok && pot_wr_addr == addr;
    assign pot_rd     = pot_hit ? pot_wr_data : (int'(addr) < NUM_NEURONS ? pot_table[addr] : '0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        fifo_rd   = 1'b0;
        load_data = '0;
        case (state)
            IDLE: if (ts_start) state_nx = PSUM;
            PSUM: if (loadable && count != '0) begin
                load      = 1'b1;
                fifo_rd   = 1'b1;
                load_data = {addr, OP_PSUM, fifo[rd_ptr]};
                state_nx  = cnt == 8'(NUM_PSUMS - 1) ? POT : PSUM;
            end
            POT: if (loadable) begin
                load      = 1'b1;
                load_data = {addr, OP_POT, pot_rd};
                state_nx  = FLAG;
            end
            FLAG: if (loadable) begin
                load      = 1'b1;
                load_data = {addr, OP_DONE, DATA_WIDTH'(0)};
                state_nx  = DRAIN;
            end
            DRAIN: if (ts_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt  <= '0;
            addr <= '0;
        end else if (state == IDLE && ts_start) begin
            cnt  <= '0;
            addr <= ts_addr;
        end else if (fifo_rd) begin
            cnt  <= cnt + 8'd1;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= fifo_wr ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= fifo_rd ? rd_ptr + PW'(1) : rd_ptr;
            count  <= count + (PW+1)'(fifo_wr) - (PW+1)'(fifo_rd);
        end

    always_ff @(posedge clk)
        if (fifo_wr) fifo[wr_ptr] <= psum_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) pot_table[i] <= '0;
        end else if (pot_wr_ok) begin
            pot_table[pot_wr_addr] <= pot_wr_data;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
        end else if (load) begin
            pkt_valid <= 1'b1;
            pkt_data  <= load_data;
        end else if (pkt_ready) begin
            pkt_valid <= 1'b0;
        end
endmodule

// File: tb/tb_spe_packet_sequencer.sv
// tb_spe_packet_sequencer: vector table plus corner sequences, packets checked
// against a queue of expected packets filled when each timestep is launched.
module tb_spe_packet_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ts_start = 1'b0;
    logic [3:0]  ts_addr = '0;
    logic        busy;
    logic        psum_valid = 1'b0;
    logic        psum_ready;
    logic [24:0] psum_data = '0;
    logic        pot_wr_en = 1'b0;
    logic [3:0]  pot_wr_addr = '0;
    logic [24:0] pot_wr_data = '0;
    logic        pkt_valid;
    logic        pkt_ready = 1'b1;
    logic [32:0] pkt_data;
    logic        ts_done;

    spe_packet_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ts_start(ts_start), .ts_addr(ts_addr), .busy(busy),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .pot_wr_en(pot_wr_en), .pot_wr_addr(pot_wr_addr), .pot_wr_data(pot_wr_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .ts_done(ts_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        addr;
        logic              pot_we;
        logic [24:0]       pot;
        logic [4:0][24:0]  ps;
        logic [32:0]       exp_pot;
    } vec_t;

    vec_t        vecs [4];
    logic [32:0] exp_q [$];
    int          compared = 0;
    int          mismatched = 0;
    int          n_hs = 0;
    int          base;
    logic        mon_hs, found;
    logic [32:0] mon_head;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_psum(input logic [24:0] d);
        logic ok;
        ok = 1'b0;
        psum_valid = 1'b1;
        psum_data = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = psum_ready;
            step();
        end
        psum_valid = 1'b0;
        if (!ok) timeout("psum_push");
    endtask

    task automatic start_ts(input logic [3:0] a);
        ts_start = 1'b1;
        ts_addr = a;
        step();
        ts_start = 1'b0;
        check1("busy_rise", busy, 1'b1);
    endtask

    task automatic write_pot(input logic [3:0] a, input logic [24:0] d);
        pot_wr_en = 1'b1;
        pot_wr_addr = a;
        pot_wr_data = d;
        step();
        pot_wr_en = 1'b0;
    endtask

    task automatic expect_ts(input logic [3:0] a, input logic [4:0][24:0] ps, input logic [32:0] pot_pkt);
        for (int k = 0; k < 5; k++) exp_q.push_back({a, 4'd0, ps[k]});
        exp_q.push_back(pot_pkt);
        exp_q.push_back({a, 4'd1, 25'd0});
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = ts_done;
        end
        if (!seen) timeout(name);
        step();
        check1({name, "_busy_fall"}, busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_hs = pkt_valid && pkt_ready;
            mon_head = exp_q.size() != 0 ? exp_q[0] : '0;
            check1("ts_done", ts_done, mon_hs && exp_q.size() != 0 && mon_head[28:25] == 4'd1);
            if (mon_hs) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL pkt_extra: got %h expected no packet", pkt_data);
                end else begin
                    check("pkt", pkt_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        vecs[0] = '{4'd0, 1'b0, 25'd0, {25'd4, 25'd3, 25'd2, 25'd1, 25'd0}, 33'h004000000};
        vecs[1] = '{4'd3, 1'b1, 25'd60, {25'd7, 25'd7, 25'd7, 25'd7, 25'd7}, 33'h06400003C};
        vecs[2] = '{4'd9, 1'b1, 25'h1FFFFFF, {25'd1, 25'h0AAAAAA, 25'h1555555, 25'd0, 25'h1FFFFFF}, 33'h125FFFFFF};
        vecs[3] = '{4'd15, 1'b0, 25'd0, {25'd500, 25'd400, 25'd300, 25'd200, 25'd100}, 33'h1E4000000};

        repeat (3) @(posedge clk);
        #1;
        check1("rst_pkt_valid", pkt_valid, 1'b0);
        check("rst_pkt_data", pkt_data, 33'h0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ts_done", ts_done, 1'b0);
        check1("rst_psum_ready", psum_ready, 1'b1);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].pot_we) write_pot(vecs[v].addr, vecs[v].pot);
            expect_ts(vecs[v].addr, vecs[v].ps, vecs[v].exp_pot);
            start_ts(vecs[v].addr);
            for (int k = 0; k < 5; k++) push_psum(vecs[v].ps[k]);
            wait_done("vec");
        end

        // backpressure: one packet held, FIFO fills, sixth psum stays for the next timestep
        expect_ts(4'd5, {25'd14, 25'd13, 25'd12, 25'd11, 25'd10}, 33'h0A4000000);
        start_ts(4'd5);
        pkt_ready = 1'b0;
        fork
            for (int k = 0; k < 6; k++) push_psum(25'(10 + k));
            begin
                for (int j = 1; j <= 10; j++) begin
                    @(negedge clk);
                    if (j >= 3) begin
                        check1("stall_valid", pkt_valid, 1'b1);
                        check("stall_hold", pkt_data, 33'h0A000000A);
                    end
                end
                check1("stall_psum_ready", psum_ready, 1'b0);
                step();
                pkt_ready = 1'b1;
            end
        join
        wait_done("stall");

        // ts_start held through the busy period, including the ts_done cycle
        expect_ts(4'd2, {25'd23, 25'd22, 25'd21, 25'd20, 25'd15}, 33'h044000000);
        base = n_hs;
        start_ts(4'd2);
        ts_start = 1'b1;
        ts_addr = 4'd7;
        for (int k = 0; k < 4; k++) push_psum(25'(20 + k));
        wait_done("coincident");
        ts_start = 1'b0;
        repeat (5) step();
        check1("coincident_idle", busy, 1'b0);
        check("coincident_count", 33'(n_hs - base), 33'd7);

        // table write to the loading index in the exact potential-load cycle
        for (int k = 1; k <= 4; k++) push_psum(25'(k));
        expect_ts(4'd0, {25'd5, 25'd4, 25'd3, 25'd2, 25'd1}, 33'h004000063);
        start_ts(4'd0);
        push_psum(25'd5);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = pkt_valid && pkt_data == 33'h000000005;
        end
        if (!found) timeout("bypass_sync");
        pot_wr_en = 1'b1;
        pot_wr_addr = 4'd0;
        pot_wr_data = 25'd99;
        step();
        pot_wr_en = 1'b0;
        wait_done("bypass");
        expect_ts(4'd0, '0, 33'h004000063);
        start_ts(4'd0);
        for (int k = 0; k < 5; k++) push_psum(25'd0);
        wait_done("bypass_followup");

        // reset mid-timestep flushes FIFO, output and potential table
        write_pot(4'd4, 25'd77);
        for (int k = 0; k < 4; k++) push_psum(25'(40 + k));
        expect_ts(4'd4, {25'd44, 25'd43, 25'd42, 25'd41, 25'd40}, 33'h084000000);
        base = n_hs;
        start_ts(4'd4);
        for (int i = 0; i < 100 && n_hs < base + 2; i++) @(negedge clk);
        if (n_hs < base + 2) timeout("reset_sync");
        step();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check1("midrst_pkt_valid", pkt_valid, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_psum_ready", psum_ready, 1'b1);
        step();
        rst_n = 1'b1;
        step();
        expect_ts(4'd4, {25'd34, 25'd33, 25'd32, 25'd31, 25'd30}, 33'h084000000);
        start_ts(4'd4);
        for (int k = 0; k < 5; k++) push_psum(25'(30 + k));
        wait_done("after_reset");
        repeat (3) step();
        check("queue_drained", 33'(exp_q.size()), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
